// File: rtl/j1_membus.sv
// j1_membus: j1 dual-port RAM with instruction fetch port and memory-mapped UART, LED and tick I/O
module j1_membus #(
   parameter int    MEMWIDTH     = 14,
   parameter int    CLKS_PER_BIT = 104,
   parameter string INIT_FILE    = ""
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [MEMWIDTH-1:0] mem_addr,
   input  logic                mem_wr,
   input  logic [15:0]         dout,
   output logic [15:0]         din,
   input  logic [MEMWIDTH-1:0] code_addr,
   output logic [15:0]         insn,
   input  logic                uart_rx,
   output logic                uart_tx,
   output logic [7:0]          leds
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
   logic [15:0] ram [2**MEMWIDTH];
   logic [15:0] io_rd, tick;
   logic [3:0] off;
   logic io_sel, io_wr, data_wr, stat_wr;
   uart_state_t tx_state, tx_state_n, rx_state, rx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
   logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
   logic [7:0] tx_shift, tx_shift_n, rx_shift, rx_shift_n, rx_byte;
   logic tx_out_n, tx_load, tx_busy, tx_ovr, tx_ovr_n;
   logic rx_s1, rx_s2, rx_prev, rx_done, rx_valid, rx_valid_n, rx_ovr, rx_ovr_n;
   assign io_sel  = &mem_addr[MEMWIDTH-1:4];
   assign off     = mem_addr[3:0];
   assign io_wr   = mem_wr && io_sel;
   assign data_wr = io_wr && off == 4'd0;
   assign stat_wr = io_wr && off == 4'd1;
   assign tx_busy = tx_state != IDLE;
   assign tx_load = data_wr && (tx_state == IDLE || (tx_state == STOP && tx_cnt == LAST));
   assign io_rd = off == 4'd0 ? {8'h00, rx_byte}
                : off == 4'd1 ? {12'h000, tx_ovr, rx_ovr, rx_valid, tx_busy}
                : off == 4'd2 ? {8'h00, leds}
                : off == 4'd3 ? tick
                : 16'h0000;
   assign tx_ovr_n   = (data_wr && !tx_load) || (tx_ovr && !(stat_wr && dout[3]));
   assign rx_valid_n = rx_done || (rx_valid && !(stat_wr && dout[1]));
   assign rx_ovr_n   = (rx_done && rx_valid) || (rx_ovr && !(stat_wr && dout[2]));
   always_ff @(posedge clk) begin
      if (mem_wr && !io_sel) ram[mem_addr] <= dout;
      insn <= reset ? 16'h0000 : ram[code_addr];
      din  <= reset ? 16'h0000 : io_sel ? io_rd : ram[mem_addr];
   end
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = (tx_state == IDLE || tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      case (tx_state)
         START: if (tx_cnt == LAST) tx_state_n = DATA;
         DATA: if (tx_cnt == LAST) begin
            tx_shift_n = tx_shift >> 1;
            tx_bit_n   = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state_n = STOP;
         end
         STOP: if (tx_cnt == LAST) tx_state_n = IDLE;
         default: ;
      endcase
      if (tx_load) begin
         tx_state_n = START;
         tx_shift_n = dout[7:0];
         tx_cnt_n   = '0;
         tx_bit_n   = '0;
      end
      tx_out_n = tx_state_n == START ? 1'b0 : tx_state_n == DATA ? tx_shift_n[0] : 1'b1;
   end
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = (rx_state == IDLE || rx_cnt == LAST) ? '0 : rx_cnt + 1'b1;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_done    = 1'b0;
      case (rx_state)
         IDLE: if (rx_prev && !rx_s2) rx_state_n = START;
         START: if (rx_cnt == HALF) begin
            rx_state_n = rx_s2 ? IDLE : DATA;
            rx_cnt_n   = '0;
         end
         DATA: if (rx_cnt == LAST) begin
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = STOP;
         end
         STOP: if (rx_cnt == LAST) begin
            rx_state_n = IDLE;
            rx_done    = rx_s2;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
         tx_ovr   <= 1'b0;
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         leds     <= '0;
         tick     <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         uart_tx  <= tx_out_n;
         tx_ovr   <= tx_ovr_n;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_byte  <= rx_done ? rx_shift : rx_byte;
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_valid <= rx_valid_n;
         rx_ovr   <= rx_ovr_n;
         leds     <= (io_wr && off == 4'd2) ? dout[7:0] : leds;
         tick     <= (io_wr && off == 4'd3) ? dout : tick + 16'd1;
      end
   end
endmodule

// File: tb/tb_j1_membus.sv
// tb_j1_membus: directed checks of RAM ports, I/O window, UART TX/RX and reset behaviour
module tb_j1_membus;
   logic clk = 1'b0, reset = 1'b1, mem_wr = 1'b0, uart_rx = 1'b1;
   logic [13:0] mem_addr = '0, code_addr = '0;
   logic [15:0] dout = '0;
   logic [15:0] din, insn;
   logic uart_tx;
   logic [7:0] leds;
   int checks = 0, errors = 0;
   logic [9:0] tx_pat = 10'b1101001010;
   always #5 clk = ~clk;
   j1_membus #(.MEMWIDTH(14), .CLKS_PER_BIT(4), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wr(mem_wr), .dout(dout), .din(din),
      .code_addr(code_addr), .insn(insn), .uart_rx(uart_rx), .uart_tx(uart_tx), .leds(leds)
   );
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic bus(input logic [13:0] a, input logic [15:0] d);
      mem_addr = a;
      dout = d;
      mem_wr = 1'b1;
      cyc(1);
      mem_wr = 1'b0;
   endtask
   task automatic rd(input logic [13:0] a);
      mem_addr = a;
      mem_wr = 1'b0;
      cyc(1);
   endtask
   task automatic send(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      cyc(4);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         cyc(4);
      end
      uart_rx = stop_bit;
      cyc(4);
      uart_rx = 1'b1;
      cyc(4);
   endtask
   initial begin
      mem_addr = 14'h3FF3;
      cyc(2);
      chk("reset_din", din, 16'h0000);
      chk("reset_insn", insn, 16'h0000);
      chk("reset_tx", {15'h0, uart_tx}, 16'h0001);
      chk("reset_leds", {8'h00, leds}, 16'h0000);
      reset = 1'b0;
      cyc(1);
      chk("tick_start", din, 16'h0000);
      chk("insn_after_reset", insn, 16'h0000);
      cyc(1);
      chk("tick_inc", din, 16'h0001);
      bus(14'h0100, 16'hBEEF);
      rd(14'h0100);
      chk("ram_read", din, 16'hBEEF);
      mem_wr = 1'b1;
      dout = 16'h1234;
      cyc(1);
      mem_wr = 1'b0;
      chk("ram_read_first", din, 16'hBEEF);
      cyc(1);
      chk("ram_new", din, 16'h1234);
      bus(14'h0005, 16'h3000);
      code_addr = 14'h0005;
      cyc(1);
      chk("insn_fetch", insn, 16'h3000);
      bus(14'h0005, 16'h4000);
      chk("insn_read_first", insn, 16'h3000);
      cyc(1);
      chk("insn_new", insn, 16'h4000);
      bus(14'h3FF3, 16'hFFFE);
      cyc(1);
      chk("tick_load", din, 16'hFFFE);
      cyc(1);
      chk("tick_next", din, 16'hFFFF);
      cyc(1);
      chk("tick_wrap", din, 16'h0000);
      code_addr = 14'h3FF2;
      bus(14'h3FF2, 16'h12A5);
      chk("leds_write", {8'h00, leds}, 16'h00A5);
      rd(14'h3FF2);
      chk("leds_read", din, 16'h00A5);
      chk("ram_under_window", insn, 16'h0000);
      bus(14'h3FF7, 16'hFFFF);
      rd(14'h3FF7);
      chk("unused_reg", din, 16'h0000);
      bus(14'h3FF0, 16'h00A5);
      mem_addr = 14'h3FF1;
      for (int i = 0; i < 40; i++) begin
         chk("uart_tx", {15'h0, uart_tx}, {15'h0, tx_pat[i/4]});
         if (i == 1) chk("tx_busy", din, 16'h0001);
         if (i == 8) chk("tx_ovr_set", din, 16'h0009);
         if (i == 5) begin
            mem_addr = 14'h3FF0;
            dout = 16'h00FF;
            mem_wr = 1'b1;
         end
         if (i == 6) begin
            mem_wr = 1'b0;
            mem_addr = 14'h3FF1;
         end
         cyc(1);
      end
      cyc(1);
      chk("tx_idle", din, 16'h0008);
      bus(14'h3FF1, 16'h0008);
      rd(14'h3FF1);
      chk("tx_ovr_clr", din, 16'h0000);
      send(8'h3C, 1'b1);
      rd(14'h3FF0);
      chk("rx_data1", din, 16'h003C);
      rd(14'h3FF1);
      chk("rx_valid", din, 16'h0002);
      send(8'h81, 1'b1);
      rd(14'h3FF0);
      chk("rx_data2", din, 16'h0081);
      rd(14'h3FF1);
      chk("rx_ovr", din, 16'h0006);
      bus(14'h3FF1, 16'h0006);
      rd(14'h3FF1);
      chk("rx_clr", din, 16'h0000);
      uart_rx = 1'b0;
      cyc(1);
      uart_rx = 1'b1;
      cyc(12);
      rd(14'h3FF1);
      chk("rx_glitch", din, 16'h0000);
      send(8'h55, 1'b0);
      rd(14'h3FF1);
      chk("rx_framing", din, 16'h0000);
      rd(14'h3FF0);
      chk("rx_framing_data", din, 16'h0081);
      bus(14'h3FF2, 16'h005A);
      bus(14'h3FF0, 16'h00C3);
      cyc(2);
      chk("tx_start_bit", {15'h0, uart_tx}, 16'h0000);
      reset = 1'b1;
      cyc(1);
      chk("reset_mid_tx", {15'h0, uart_tx}, 16'h0001);
      chk("reset_mid_leds", {8'h00, leds}, 16'h0000);
      chk("reset_mid_din", din, 16'h0000);
      mem_addr = 14'h3FF3;
      reset = 1'b0;
      cyc(1);
      chk("reset_mid_tick", din, 16'h0000);
      rd(14'h3FF1);
      chk("reset_mid_status", din, 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
